// File: rtl/nonce_dispatch_sched.sv
// nonce_dispatch_sched: hands out a contiguous nonce range to NUM_CORES
// double-SHA256 cores, collects each core's h0 and tracks the smallest match.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   job_start                 job launch pulse (honoured only while idle)
//   nonce_base, nonce_count   job range, sampled on an accepted job_start
//   target_h0                 match threshold (core_h0 < target_h0, unsigned)
//   abort                     stop issuing and drain in-flight cores
//   core_start, core_nonce    per-core start pulse and nonce (32 bits per core)
//   core_done, core_h0        per-core completion pulse and its h0 word
//   busy, job_done            activity flag and end-of-job pulse
//   found, found_nonce        smallest matching nonce of current/last job
//   hashes_done               results collected in current/last job
//   protocol_err              sticky: done from a core that was not busy
module nonce_dispatch_sched #(
    parameter int unsigned NUM_CORES  = 4,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    job_start,
    input  logic [31:0]             nonce_base,
    input  logic [31:0]             nonce_count,
    input  logic [31:0]             target_h0,
    input  logic                    abort,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [32*NUM_CORES-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [32*NUM_CORES-1:0] core_h0,
    output logic                    busy,
    output logic                    job_done,
    output logic                    found,
    output logic [31:0]             found_nonce,
    output logic [31:0]             hashes_done,
    output logic                    protocol_err
);

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned IDX_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W   = $clog2(NUM_CORES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    state_e                                state_q, state_d;
    logic [NONCE_W-1:0]                    next_nonce_q, next_nonce_d;
    logic [31:0]                           remaining_q, remaining_d;
    logic [31:0]                           target_q, target_d;
    logic [NUM_CORES-1:0]                  core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0]                  core_start_q, core_start_d;
    logic [NUM_CORES-1:0][NONCE_W-1:0]     core_nonce_q, core_nonce_d;
    logic                                  job_done_q, job_done_d;
    logic                                  found_q, found_d;
    logic [NONCE_W-1:0]                    found_nonce_q, found_nonce_d;
    logic [31:0]                           hashes_done_q, hashes_done_d;
    logic                                  protocol_err_q, protocol_err_d;
    logic                                  busy_q, busy_d;

    logic [NUM_CORES-1:0]                  valid_done;
    logic [NUM_CORES-1:0]                  spurious_done;
    logic [CNT_W-1:0]                      done_cnt;
    logic                                  match_any;
    logic [NONCE_W-1:0]                    match_min;
    logic                                  free_any;
    logic [IDX_W-1:0]                      free_idx;

    // Per-cycle result collection: count legal dones, find the smallest match.
    always_comb begin
        valid_done    = core_done & core_busy_q;
        spurious_done = core_done & ~core_busy_q;
        done_cnt      = '0;
        match_any     = 1'b0;
        match_min     = '1;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            done_cnt = done_cnt + CNT_W'(valid_done[k]);
            if (valid_done[k] && (core_h0[NONCE_W*k +: NONCE_W] < target_q)) begin
                if (!match_any || (core_nonce_q[k] < match_min)) begin
                    match_min = core_nonce_q[k];
                end
                match_any = 1'b1;
            end
        end
    end

    // Lowest-index core that is idle at the start of the cycle.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (!free_any && !core_busy_q[k]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        next_nonce_d   = next_nonce_q;
        remaining_d    = remaining_q;
        target_d       = target_q;
        core_busy_d    = core_busy_q;
        core_start_d   = '0;
        core_nonce_d   = core_nonce_q;
        job_done_d     = (state_q == ST_FINISH);
        found_d        = found_q;
        found_nonce_d  = found_nonce_q;
        hashes_done_d  = hashes_done_q;
        protocol_err_d = protocol_err_q | (|spurious_done);

        // Collection runs before the issue decision so a freed core is not
        // re-used until the following cycle and DRAIN sees this cycle's dones.
        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            core_busy_d   = core_busy_q & ~valid_done;
            hashes_done_d = hashes_done_q + 32'(done_cnt);
            if (match_any) begin
                found_d = 1'b1;
                if (!found_q || (match_min < found_nonce_q)) begin
                    found_nonce_d = match_min;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (job_start) begin
                    next_nonce_d   = nonce_base;
                    remaining_d    = nonce_count;
                    target_d       = target_h0;
                    found_d        = 1'b0;
                    found_nonce_d  = '0;
                    hashes_done_d  = '0;
                    protocol_err_d = 1'b0;
                    state_d        = (nonce_count == 32'd0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                // A match seen this cycle already blocks the issue in early-exit mode.
                if (abort || (EARLY_EXIT && match_any)) begin
                    state_d = ST_DRAIN;
                end else if (free_any) begin
                    core_start_d[free_idx] = 1'b1;
                    core_nonce_d[free_idx] = next_nonce_q;
                    core_busy_d[free_idx]  = 1'b1;
                    next_nonce_d           = next_nonce_q + 32'd1;
                    remaining_d            = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (core_busy_d == '0) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            next_nonce_q   <= '0;
            remaining_q    <= '0;
            target_q       <= '0;
            core_busy_q    <= '0;
            core_start_q   <= '0;
            core_nonce_q   <= '0;
            job_done_q     <= 1'b0;
            found_q        <= 1'b0;
            found_nonce_q  <= '0;
            hashes_done_q  <= '0;
            protocol_err_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_nonce_q   <= next_nonce_d;
            remaining_q    <= remaining_d;
            target_q       <= target_d;
            core_busy_q    <= core_busy_d;
            core_start_q   <= core_start_d;
            core_nonce_q   <= core_nonce_d;
            job_done_q     <= job_done_d;
            found_q        <= found_d;
            found_nonce_q  <= found_nonce_d;
            hashes_done_q  <= hashes_done_d;
            protocol_err_q <= protocol_err_d;
            busy_q         <= busy_d;
        end
    end

    assign core_start   = core_start_q;
    assign core_nonce   = core_nonce_q;
    assign busy         = busy_q;
    assign job_done     = job_done_q;
    assign found        = found_q;
    assign found_nonce  = found_nonce_q;
    assign hashes_done  = hashes_done_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_nonce_dispatch_sched.sv
// Bench for nonce_dispatch_sched: two instances (EARLY_EXIT=0 and =1) share
// clock and reset, each with a behavioural model of four hash cores.
module tb_nonce_dispatch_sched;

    localparam int unsigned NC  = 4;
    localparam int          LAT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              js[2];
    logic              ab[2];
    logic [31:0]       nb[2];
    logic [31:0]       ncnt[2];
    logic [31:0]       th[2];
    logic [NC-1:0]     cs[2];
    logic [NC-1:0]     mdone[2];
    logic [NC-1:0]     spur[2];
    logic [NC-1:0]     cdone[2];
    logic [32*NC-1:0]  cn[2];
    logic [32*NC-1:0]  mh0[2];
    logic              bz[2];
    logic              jd[2];
    logic              fd[2];
    logic              pe[2];
    logic [31:0]       fn[2];
    logic [31:0]       hd[2];

    assign cdone[0] = mdone[0] | spur[0];
    assign cdone[1] = mdone[1] | spur[1];

    nonce_dispatch_sched #(.NUM_CORES(NC), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .job_start(js[0]), .nonce_base(nb[0]),
        .nonce_count(ncnt[0]), .target_h0(th[0]), .abort(ab[0]),
        .core_start(cs[0]), .core_nonce(cn[0]), .core_done(cdone[0]), .core_h0(mh0[0]),
        .busy(bz[0]), .job_done(jd[0]), .found(fd[0]), .found_nonce(fn[0]),
        .hashes_done(hd[0]), .protocol_err(pe[0])
    );

    nonce_dispatch_sched #(.NUM_CORES(NC), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .job_start(js[1]), .nonce_base(nb[1]),
        .nonce_count(ncnt[1]), .target_h0(th[1]), .abort(ab[1]),
        .core_start(cs[1]), .core_nonce(cn[1]), .core_done(cdone[1]), .core_h0(mh0[1]),
        .busy(bz[1]), .job_done(jd[1]), .found(fd[1]), .found_nonce(fn[1]),
        .hashes_done(hd[1]), .protocol_err(pe[1])
    );

    // Core model configuration: up to two "special" nonces return m_h0v;
    // with m_gang set, those two cores hold their done until both are ready.
    logic [31:0] m_a[2];
    logic [31:0] m_b[2];
    logic [31:0] m_h0v[2];
    bit          m_en[2];
    bit          m_gang[2];

    int          cnt[2][NC];
    logic [31:0] lat_n[2][NC];
    bit          wt[2][NC];
    int          cyc;

    function automatic bit is_special(input int i, input logic [31:0] n);
        return m_en[i] && ((n == m_a[i]) || (n == m_b[i]));
    endfunction

    function automatic logic [31:0] h0_of(input int i, input logic [31:0] n);
        return is_special(i, n) ? m_h0v[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int n_waiting(input int i);
        int s = 0;
        for (int k = 0; k < NC; k++) s += int'(wt[i][k]);
        return s;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mdone[i] <= '0;
                mh0[i]   <= '0;
                for (int k = 0; k < NC; k++) begin
                    cnt[i][k]   <= 0;
                    lat_n[i][k] <= '0;
                    wt[i][k]    <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mdone[i] <= '0;
                for (int k = 0; k < NC; k++) begin
                    if (m_gang[i] && (n_waiting(i) == 2) && wt[i][k]) begin
                        wt[i][k]           <= 1'b0;
                        mdone[i][k]        <= 1'b1;
                        mh0[i][32*k +: 32] <= h0_of(i, lat_n[i][k]);
                    end else if (cs[i][k]) begin
                        cnt[i][k]   <= LAT - 1;
                        lat_n[i][k] <= cn[i][32*k +: 32];
                    end else if (cnt[i][k] != 0) begin
                        cnt[i][k] <= cnt[i][k] - 1;
                        if (cnt[i][k] == 1) begin
                            if (m_gang[i] && is_special(i, lat_n[i][k])) begin
                                wt[i][k] <= 1'b1;
                            end else begin
                                mdone[i][k]        <= 1'b1;
                                mh0[i][32*k +: 32] <= h0_of(i, lat_n[i][k]);
                            end
                        end
                    end
                end
            end
        end
    end

    // Scoreboard
    typedef struct {
        int          inst;
        logic [31:0] nonce;
    } iss_t;

    typedef struct {
        int          inst;
        bit          found;
        logic [31:0] fnonce;
        logic [31:0] hashes;
        bit          perr;
        int          maxd;
        int          start_cyc;
        int          lat;
        bit          tail;
    } job_t;

    iss_t iss_q[$];
    job_t job_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_iss  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic push_iss(input int i, input logic [31:0] n);
        iss_t e;
        e.inst  = i;
        e.nonce = n;
        iss_q.push_back(e);
    endtask

    task automatic push_job(input int i, input bit f, input logic [31:0] fnv,
                            input logic [31:0] h, input bit perr, input int maxd,
                            input int sc, input int lat, input bit tail);
        job_t j;
        j.inst = i; j.found = f; j.fnonce = fnv; j.hashes = h; j.perr = perr;
        j.maxd = maxd; j.start_cyc = sc; j.lat = lat; j.tail = tail;
        job_q.push_back(j);
    endtask

    // Monitor
    int          last_done[2];
    int          maxd[2];
    logic [31:0] prev_hd[2];

    initial begin
        iss_t e;
        job_t j;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int i = 0; i < 2; i++) begin
                    maxd[i]      = 0;
                    prev_hd[i]   = '0;
                    last_done[i] = -100;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < NC; k++) begin
                        if (cs[i][k]) begin
                            if (i == 1) check("start_after_found", 32'(fd[1]), 32'd0);
                            if (chk_iss) begin
                                if (iss_q.size() == 0) begin
                                    fail_now("issue_extra");
                                end else begin
                                    e = iss_q.pop_front();
                                    check("issue_inst", i, e.inst);
                                    check("issue_nonce", cn[i][32*k +: 32], e.nonce);
                                end
                            end
                        end
                    end
                    if (|cdone[i]) last_done[i] = cyc;
                    if ((hd[i] > prev_hd[i]) && (int'(hd[i] - prev_hd[i]) > maxd[i]))
                        maxd[i] = int'(hd[i] - prev_hd[i]);
                    prev_hd[i] = hd[i];
                    if (jd[i]) begin
                        if (job_q.size() == 0) begin
                            fail_now("job_done_extra");
                        end else begin
                            j = job_q.pop_front();
                            check("job_inst", i, j.inst);
                            check("found", 32'(fd[i]), 32'(j.found));
                            if (j.found) check("found_nonce", fn[i], j.fnonce);
                            check("hashes_done", hd[i], j.hashes);
                            check("protocol_err", 32'(pe[i]), 32'(j.perr));
                            check("max_hash_step", maxd[i], j.maxd);
                            check("busy_at_job_done", 32'(bz[i]), 32'd0);
                            if (j.lat >= 0) check("job_done_latency", cyc - j.start_cyc, j.lat);
                            if (j.tail) check("last_done_to_job_done", cyc - last_done[i], 32'd2);
                        end
                        maxd[i] = 0;
                    end
                end
            end
        end
    end

    // Stimulus
    task automatic start_job(input int i, input logic [31:0] base, input logic [31:0] n,
                             input logic [31:0] tgt, output int sc);
        @(posedge clk); #1;
        nb[i] = base; ncnt[i] = n; th[i] = tgt; js[i] = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        js[i] = 1'b0;
    endtask

    task automatic wait_jobs(input int budget);
        int n = 0;
        while ((job_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        if (job_q.size() != 0) begin
            fail_now("job_done_timeout");
            job_q.delete();
        end
        check("issues_pending", iss_q.size(), 32'd0);
        iss_q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input int i);
        check("rst_core_start", 32'(cs[i]), 32'd0);
        check("rst_core_nonce_any", 32'(|cn[i]), 32'd0);
        check("rst_busy", 32'(bz[i]), 32'd0);
        check("rst_job_done", 32'(jd[i]), 32'd0);
        check("rst_found", 32'(fd[i]), 32'd0);
        check("rst_found_nonce", fn[i], 32'd0);
        check("rst_hashes_done", hd[i], 32'd0);
        check("rst_protocol_err", 32'(pe[i]), 32'd0);
    endtask

    initial begin
        int sc;
        int n;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            js[i] = 1'b0; ab[i] = 1'b0; nb[i] = '0; ncnt[i] = '0; th[i] = '0;
            spur[i] = '0; m_a[i] = '0; m_b[i] = '0; m_h0v[i] = '0;
            m_en[i] = 1'b0; m_gang[i] = 1'b0;
        end
        repeat (3) @(posedge clk); #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Plain sweep of 0x10..0x19, nothing matches.
        for (int k = 0; k < 10; k++) push_iss(0, 32'h10 + 32'(k));
        start_job(0, 32'h10, 32'd10, 32'd0, sc);
        push_job(0, 1'b0, 32'd0, 32'd10, 1'b0, 1, sc, -1, 1'b1);
        check("busy_in_run", 32'(bz[0]), 32'd1);
        check("no_start_at_t1", 32'(cs[0]), 32'd0);
        @(posedge clk); #1;
        check("first_start_at_t2", 32'(cs[0]), 32'h1);
        wait_jobs(300);

        // Nonces 3 and 9 match and complete in the same cycle.
        m_en[0] = 1'b1; m_a[0] = 32'd3; m_b[0] = 32'd9; m_h0v[0] = 32'd0; m_gang[0] = 1'b1;
        for (int k = 0; k < 10; k++) push_iss(0, 32'(k));
        start_job(0, 32'd0, 32'd10, 32'd1, sc);
        push_job(0, 1'b1, 32'd3, 32'd10, 1'b0, 2, sc, -1, 1'b1);
        wait_jobs(300);
        m_en[0] = 1'b0; m_gang[0] = 1'b0;

        // Nonce wrap-around.
        push_iss(0, 32'hFFFF_FFFE); push_iss(0, 32'hFFFF_FFFF);
        push_iss(0, 32'h0000_0000); push_iss(0, 32'h0000_0001);
        start_job(0, 32'hFFFF_FFFE, 32'd4, 32'd0, sc);
        push_job(0, 1'b0, 32'd0, 32'd4, 1'b0, 1, sc, -1, 1'b1);
        wait_jobs(300);

        // Empty job; a second job_start while busy must be ignored.
        start_job(0, 32'h40, 32'd0, 32'd0, sc);
        push_job(0, 1'b0, 32'd0, 32'd0, 1'b0, 0, sc, 2, 1'b0);
        check("busy_in_finish", 32'(bz[0]), 32'd1);
        nb[0] = 32'h500; ncnt[0] = 32'd5; js[0] = 1'b1;
        @(posedge clk); #1;
        js[0] = 1'b0;
        wait_jobs(50);

        // Abort with two cores in flight plus a spurious done on idle core 3.
        push_iss(0, 32'h100); push_iss(0, 32'h101);
        start_job(0, 32'h100, 32'd50, 32'd0, sc);
        push_job(0, 1'b0, 32'd0, 32'd2, 1'b1, 1, sc, -1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ab[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        spur[0] = 4'b1000;
        @(posedge clk); #1;
        spur[0] = '0;
        check("protocol_err_set", 32'(pe[0]), 32'd1);
        check("spurious_not_counted", hd[0], 32'd0);
        wait_jobs(100);
        ab[0] = 1'b0;

        // Early exit: nonce 6 matches, nonces 0..8 are the only ones issued.
        m_en[1] = 1'b1; m_a[1] = 32'd6; m_b[1] = 32'd6; m_h0v[1] = 32'h0000_0800;
        for (int k = 0; k < 9; k++) push_iss(1, 32'(k));
        start_job(1, 32'd0, 32'd100, 32'h0000_1000, sc);
        push_job(1, 1'b1, 32'd6, 32'd9, 1'b0, 1, sc, -1, 1'b1);
        wait_jobs(400);
        m_en[1] = 1'b0;

        // Reset in the middle of a job.
        chk_iss = 1'b0;
        m_en[0] = 1'b1; m_a[0] = 32'h201; m_b[0] = 32'h201; m_h0v[0] = 32'd0;
        start_job(0, 32'h200, 32'd20, 32'h10, sc);
        n = 0;
        while (!fd[0] && (n < 100)) begin
            @(posedge clk); #1;
            n++;
        end
        check("found_before_reset", 32'(fd[0]), 32'd1);
        check("busy_before_reset", 32'(bz[0]), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        check_reset_outputs(0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_en[0] = 1'b0;
        iss_q.delete();
        chk_iss = 1'b1;
        repeat (2) @(posedge clk);

        // Short job after reset to confirm no stale core state.
        push_iss(0, 32'h300); push_iss(0, 32'h301);
        start_job(0, 32'h300, 32'd2, 32'd0, sc);
        push_job(0, 1'b0, 32'd0, 32'd2, 1'b0, 1, sc, -1, 1'b1);
        wait_jobs(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
